waveform_capture_ctrl: RTL

//  Triggered capture/scheduling controller feeding the waveform display. It accepts 8-bit
//  ECG samples over a valid/ready handshake and arms on a rising threshold crossing. It

---
 rtl/waveform_capture_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/waveform_capture_ctrl.sv
// waveform_capture_ctrl
// Triggered, double-buffered capture controller for the waveform display.
// Samples arrive over a valid/ready handshake. A rising crossing of
// trigger_level (or force_trig) starts a capture of one screen of samples
// into the back bank. The banks swap only at a frame boundary, so the display
// never tears. The front bank is read back per display column as signal_out.
module waveform_capture_ctrl #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  sample_in,
    input  logic        sample_valid,
    output logic        sample_ready,
    input  logic        arm,
    input  logic        force_trig,
    input  logic        auto_rearm,
    input  logic [7:0]  trigger_level,
    input  logic        frame_start,
    input  logic [10:0] hcount,
    output logic [7:0]  signal_out,
    output logic        signal_valid,
    output logic        capture_done,
    output logic [1:0]  state
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_HOLD    = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE_ADDR   = ADDR_W'(1);
    localparam logic [10:0]       DEPTH_COLS = 11'(DEPTH);

    // Control registers and their next-state values
    logic [1:0]        state_q,        state_d;
    logic [7:0]        prev_q,         prev_d;
    logic [ADDR_W-1:0] wr_ptr_q,       wr_ptr_d;
    logic              front_q,        front_d;
    logic              signal_valid_q, signal_valid_d;
    logic              capture_done_q, capture_done_d;

    // Read-side registers: raw RAM output plus a flag saying it may be shown
    logic [7:0]        rd_data_q;
    logic              show_q;

    // Two banks back to back; the bank bit is the address MSB
    logic [7:0]        buffer_mem [0:2*DEPTH-1];

    // Write-port controls decided by the FSM
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;

    logic              accept;
    logic              trigger_hit;
    logic              hcount_in_range;
    logic [ADDR_W:0]   rd_addr;
    logic [ADDR_W:0]   wr_full_addr;

    assign sample_ready    = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
    assign accept          = sample_valid && sample_ready;
    assign trigger_hit     = force_trig ||
                             ((prev_q < trigger_level) && (sample_in >= trigger_level));
    assign hcount_in_range = (hcount < DEPTH_COLS);
    assign rd_addr         = {front_q, hcount[ADDR_W-1:0]};
    assign wr_full_addr    = {~front_q, wr_addr};

    // Next-state logic: arming, trigger detection, capture sequencing and the bank swap
    always_comb begin
        state_d        = state_q;
        prev_d         = prev_q;
        wr_ptr_d       = wr_ptr_q;
        front_d        = front_q;
        signal_valid_d = signal_valid_q;
        capture_done_d = 1'b0;
        wr_en          = 1'b0;
        wr_addr        = wr_ptr_q;

        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d = ST_ARMED;
                    prev_d  = 8'hFF;
                end
            end

            ST_ARMED: begin
                if (accept) begin
                    prev_d = sample_in;
                    if (trigger_hit) begin
                        wr_en    = 1'b1;
                        wr_addr  = '0;
                        wr_ptr_d = ONE_ADDR;
                        state_d  = ST_CAPTURE;
                    end
                end
            end

            ST_CAPTURE: begin
                if (accept) begin
                    wr_en   = 1'b1;
                    wr_addr = wr_ptr_q;
                    if (wr_ptr_q == LAST_ADDR) begin
                        wr_ptr_d       = '0;
                        state_d        = ST_HOLD;
                        capture_done_d = 1'b1;
                    end else begin
                        wr_ptr_d = wr_ptr_q + ONE_ADDR;
                    end
                end
            end

            ST_HOLD: begin
                if (frame_start) begin
                    front_d        = ~front_q;
                    signal_valid_d = 1'b1;
                    if (auto_rearm) begin
                        state_d = ST_ARMED;
                        prev_d  = 8'hFF;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state registers with synchronous reset; reset dominates every input
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            prev_q         <= 8'hFF;
            wr_ptr_q       <= '0;
            front_q        <= 1'b0;
            signal_valid_q <= 1'b0;
            capture_done_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            prev_q         <= prev_d;
            wr_ptr_q       <= wr_ptr_d;
            front_q        <= front_d;
            signal_valid_q <= signal_valid_d;
            capture_done_q <= capture_done_d;
        end
    end

    // Buffer write port into the back bank; RAM contents are never cleared
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            buffer_mem[wr_full_addr] <= sample_in;
        end
    end

    // Buffer read port from the front bank, registered for one cycle of latency
    always_ff @(posedge clk) begin
        rd_data_q <= buffer_mem[rd_addr];
    end

    // Display gate: out-of-range columns and reads before a complete capture show zero
    always_ff @(posedge clk) begin
        if (reset) begin
            show_q <= 1'b0;
        end else begin
            show_q <= signal_valid_q && hcount_in_range;
        end
    end

    assign signal_out   = (show_q && signal_valid_q) ? rd_data_q : 8'd0;
    assign signal_valid = signal_valid_q;
    assign capture_done = capture_done_q;
    assign state        = state_q;

endmodule
